// File: rtl/logic_trigger_scheduler_if.sv
// Bundle of trigger-request, fabric-activity and pass-control signals shared by
// the trigger scheduler (slave) and whatever drives the trigger sources (master).
`timescale 1ns/1ps

interface logic_trigger_scheduler_if #(
    parameter int N_REQ = 4
);
    logic             enable;
    logic [N_REQ-1:0] req;
    logic             activity;
    logic             err_clr;
    logic [N_REQ-1:0] grant;
    logic             logic_reset;
    logic             busy;
    logic             timeout_err;

    modport master (
        output enable, req, activity, err_clr,
        input  grant, logic_reset, busy, timeout_err
    );

    modport slave (
        input  enable, req, activity, err_clr,
        output grant, logic_reset, busy, timeout_err
    );
endinterface

// File: rtl/logic_trigger_scheduler.sv
// Round-robin trigger scheduler: one granted trigger per logic pass, then wait for
// fabric quiet and pulse logic_reset. Optional SETTLE watchdog under WATCHDOG_EN.
`timescale 1ns/1ps

module logic_trigger_scheduler #(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 256
) (
    input logic                      clk,
    input logic                      reset,
    logic_trigger_scheduler_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int QW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_MAX  = QW'(SETTLE_CYCLES);
    localparam logic [QW-1:0] Q_LAST = QW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [N_REQ-1:0]   pending_r, pending_s;
    logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [QW-1:0]      quiet_r, quiet_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic               logic_reset_r;
    logic               busy_r;
    int                 gidx_s;

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_ONE  = WW'(1);
    localparam logic [WW-1:0] W_MAX  = WW'(TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0]      wd_r, wd_s;
    logic               to_hit_s;
    logic               timeout_err_r;
`endif

    // Pick the pending bit with the smallest forward distance from ptr (wrapping).
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                                 input logic [PTR_W-1:0] ptr);
        logic [N_REQ-1:0] pick;
        int               best_d;
        int               d;
        pick   = '0;
        best_d = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(ptr)) d = i - int'(ptr);
            else                d = i + N_REQ - int'(ptr);
            if (pend[i] && (d < best_d)) begin
                best_d  = d;
                pick    = '0;
                pick[i] = 1'b1;
            end else begin
                best_d = best_d;
            end
        end
        return pick;
    endfunction

    // Next-state, pending-request and counter logic.
    always_comb begin
        // A request seen during its own grant cycle survives the clear.
        pending_s = bus.req | (pending_r & ~grant_r);
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        quiet_s   = quiet_r;
        gidx_s    = 0;
`ifdef WATCHDOG_EN
        wd_s      = wd_r;
        to_hit_s  = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_r[i]) gidx_s = i;
            else            gidx_s = gidx_s;
        end
        case (state_r)
            IDLE: begin
                if (bus.enable && (|pending_r)) state_s = GRANT;
                else                            state_s = IDLE;
            end
            GRANT: begin
                quiet_s = '0;
`ifdef WATCHDOG_EN
                wd_s    = '0;
`endif
                if (gidx_s == N_REQ - 1) rr_ptr_s = '0;
                else                     rr_ptr_s = PTR_W'(gidx_s + 1);
                state_s = SETTLE;
            end
            SETTLE: begin
                if (bus.activity)         quiet_s = '0;
                else if (quiet_r != Q_MAX) quiet_s = quiet_r + Q_ONE;
                else                       quiet_s = quiet_r;
`ifdef WATCHDOG_EN
                if (wd_r != W_MAX) wd_s = wd_r + W_ONE;
                else               wd_s = wd_r;
`endif
                if (!bus.activity && (quiet_r == Q_LAST)) begin
                    state_s = CLEAR;
`ifdef WATCHDOG_EN
                end else if (wd_r == W_LAST) begin
                    state_s  = CLEAR;
                    to_hit_s = 1'b1;
`endif
                end else begin
                    state_s = SETTLE;
                end
            end
            CLEAR: begin
                state_s = IDLE;
            end
            default: begin
                state_s = CLEAR;
            end
        endcase
        if (state_s == GRANT) grant_s = rr_pick(pending_s, rr_ptr_s);
        else                  grant_s = '0;
    end

    // State, pending set and next-state-decoded outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= CLEAR;
            pending_r     <= '0;
            rr_ptr_r      <= '0;
            quiet_r       <= '0;
            grant_r       <= '0;
            logic_reset_r <= 1'b1;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            rr_ptr_r      <= rr_ptr_s;
            quiet_r       <= quiet_s;
            grant_r       <= grant_s;
            logic_reset_r <= (state_s == CLEAR);
            busy_r        <= (state_s != IDLE);
        end
    end

`ifdef WATCHDOG_EN
    // Watchdog counter and sticky timeout flag; a new timeout beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_r          <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            wd_r <= wd_s;
            if (to_hit_s)         timeout_err_r <= 1'b1;
            else if (bus.err_clr) timeout_err_r <= 1'b0;
            else                  timeout_err_r <= timeout_err_r;
        end
    end
    assign bus.timeout_err = timeout_err_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant       = grant_r;
    assign bus.logic_reset = logic_reset_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_logic_trigger_scheduler.sv
// Scoreboard bench for logic_trigger_scheduler: expected grants are queued when
// requests are driven and popped as grants appear; pass timing checked per task.
`timescale 1ns/1ps

module tb_logic_trigger_scheduler;
    localparam int N_REQ         = 4;
    localparam int SETTLE_CYCLES = 4;
    localparam int TIMEOUT       = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [N_REQ-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_trigger_scheduler_if #(.N_REQ(N_REQ)) bus();

    logic_trigger_scheduler #(
        .N_REQ(N_REQ), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic wait_grant(input int bound, output logic [N_REQ-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.grant !== '0) begin
                g = bus.grant;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_clear(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.logic_reset === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_req(input logic [N_REQ-1:0] r);
        @(negedge clk);
        bus.req = r;
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic check_grant(input string name, input logic [N_REQ-1:0] g);
        logic [N_REQ-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got grant %b, scoreboard empty", name, g);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: grant %b, expected %b", name, g, e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.logic_reset !== 1'b1 || bus.grant !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: lr=%b grant=%b busy=%b, expected lr=1 grant=0000 busy=1",
                     bus.logic_reset, bus.grant, bus.busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.logic_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_cycle: logic_reset=%b, expected 1", bus.logic_reset);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.logic_reset !== 1'b0 || bus.grant !== '0 || bus.busy !== 1'b0 ||
                bus.timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: lr=%b grant=%b busy=%b terr=%b, expected all 0",
                         bus.logic_reset, bus.grant, bus.busy, bus.timeout_err);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] g;
        int tg, tc, prev_tc;
        prev_tc = -1;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        pulse_req(4'b1111);
        for (int p = 0; p < 4; p++) begin
            wait_grant(30, g, tg);
            check_grant("rr_order", g);
            if (p > 0) begin
                n_checks++;
                if (tg - prev_tc !== 2) begin
                    n_fail++;
                    $display("FAIL rr_gap: clear-to-grant %0d cycles, expected 2", tg - prev_tc);
                end
            end
            wait_clear(30, tc);
            n_checks++;
            if (tc - tg !== SETTLE_CYCLES + 1) begin
                n_fail++;
                $display("FAIL rr_pass_len: %0d cycles, expected %0d", tc - tg, SETTLE_CYCLES + 1);
            end
            prev_tc = tc;
        end
        wait_grant(20, g, tg);
        n_checks++;
        if (g !== '0) begin
            n_fail++;
            $display("FAIL rr_no_repeat: grant %b, expected none", g);
        end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] g;
        int tg, tc;
        exp_q.push_back(4'b0001);
        pulse_req(4'b0001);
        wait_grant(20, g, tg);
        check_grant("single_grant", g);
        @(negedge clk);
        n_checks++;
        if (bus.grant !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse: grant=%b busy=%b, expected 0000 and 1", bus.grant, bus.busy);
        end
        wait_clear(30, tc);
        n_checks++;
        if (tc - tg !== SETTLE_CYCLES + 1) begin
            n_fail++;
            $display("FAIL single_clear: %0d cycles after grant, expected %0d", tc - tg, SETTLE_CYCLES + 1);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.logic_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b lr=%b, expected 0 0", bus.busy, bus.logic_reset);
        end
    endtask

    task automatic test_activity();
        logic [N_REQ-1:0] g;
        int tg, tc;
        // Activity for 10 cycles from the grant cycle delays the clear.
        exp_q.push_back(4'b0010);
        pulse_req(4'b0010);
        wait_grant(20, g, tg);
        bus.activity = 1'b1;
        check_grant("act_grant", g);
        repeat (10) @(negedge clk);
        bus.activity = 1'b0;
        wait_clear(40, tc);
        n_checks++;
        if (tc - tg !== 10 + SETTLE_CYCLES) begin
            n_fail++;
            $display("FAIL act_long: clear %0d cycles after grant, expected %0d", tc - tg, 10 + SETTLE_CYCLES);
        end
        // A blip on the last quiet cycle restarts the quiet count.
        exp_q.push_back(4'b0010);
        pulse_req(4'b0010);
        wait_grant(20, g, tg);
        check_grant("act_grant2", g);
        repeat (SETTLE_CYCLES) @(negedge clk);
        bus.activity = 1'b1;
        @(negedge clk);
        bus.activity = 1'b0;
        wait_clear(40, tc);
        n_checks++;
        if (tc - tg !== 2 * SETTLE_CYCLES + 1) begin
            n_fail++;
            $display("FAIL act_last_quiet: clear %0d cycles after grant, expected %0d",
                     tc - tg, 2 * SETTLE_CYCLES + 1);
        end
    endtask

    task automatic test_repend();
        logic [N_REQ-1:0] g;
        int tg, tc;
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        pulse_req(4'b1111);
        for (int p = 0; p < 5; p++) begin
            wait_grant(30, g, tg);
            if (p == 0) bus.req = 4'b0100;
            check_grant("repend_order", g);
            if (p == 0) begin
                @(negedge clk);
                bus.req = '0;
            end
            wait_clear(30, tc);
        end
        wait_grant(20, g, tg);
        n_checks++;
        if (g !== '0) begin
            n_fail++;
            $display("FAIL repend_extra: grant %b, expected none", g);
        end
    endtask

    task automatic test_enable();
        logic [N_REQ-1:0] g;
        int tg, tc;
        exp_q.push_back(4'b0001);
        pulse_req(4'b0001);
        wait_grant(20, g, tg);
        bus.enable = 1'b0;
        check_grant("en_grant", g);
        exp_q.push_back(4'b1000);
        pulse_req(4'b1000);
        wait_clear(30, tc);
        n_checks++;
        if (tc - tg !== SETTLE_CYCLES + 1) begin
            n_fail++;
            $display("FAIL en_finish: clear %0d cycles after grant, expected %0d", tc - tg, SETTLE_CYCLES + 1);
        end
        wait_grant(20, g, tg);
        n_checks++;
        if (g !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_hold: grant=%b busy=%b while disabled, expected 0000 0", g, bus.busy);
        end
        bus.enable = 1'b1;
        wait_grant(10, g, tg);
        check_grant("en_resume", g);
        wait_clear(30, tc);
    endtask

    task automatic test_watchdog();
        logic [N_REQ-1:0] g;
        int tg, tc;
        exp_q.push_back(4'b0010);
        bus.activity = 1'b1;
        pulse_req(4'b0010);
        wait_grant(20, g, tg);
        check_grant("wd_grant", g);
`ifdef WATCHDOG_EN
        wait_clear(TIMEOUT + 20, tc);
        n_checks++;
        if (tc - tg !== TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL wd_clear: clear %0d cycles after grant, expected %0d", tc - tg, TIMEOUT + 1);
        end
        n_checks++;
        if (bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_set: timeout_err=%b, expected 1", bus.timeout_err);
        end
        bus.activity = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: timeout_err=%b, expected 1", bus.timeout_err);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clr: timeout_err=%b, expected 0", bus.timeout_err);
        end
`else
        wait_clear(TIMEOUT + 40, tc);
        n_checks++;
        if (tc !== -1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nowd_stuck: clear at %0d busy=%b, expected no clear and busy 1", tc, bus.busy);
        end
        bus.activity = 1'b0;
        wait_clear(SETTLE_CYCLES + 5, tc);
        n_checks++;
        if (tc === -1 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nowd_release: clear at %0d terr=%b, expected clear and terr 0", tc, bus.timeout_err);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.enable   = 1'b1;
        bus.req      = '0;
        bus.activity = 1'b0;
        bus.err_clr  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_activity();
        test_repend();
        test_enable();
        test_watchdog();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d grants never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
